// File: rtl/rtc_field_editor_pkg.sv
// Shared definitions for the RTC field editor: mode encodings, field limits
// and the days-in-month helper (exact for years 2000..2099).
package rtc_pkg;

    localparam int unsigned MODE_W  = 3;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned DAY_W   = 5;
    localparam int unsigned MONTH_W = 4;
    localparam int unsigned YEAR_W  = 7;
    localparam int unsigned FIELD_N = 6;

    typedef enum logic [MODE_W-1:0] {
        MODE_NORMAL = 3'd0,
        MODE_SS     = 3'd1,
        MODE_MI     = 3'd2,
        MODE_HH     = 3'd3,
        MODE_DD     = 3'd4,
        MODE_MO     = 3'd5,
        MODE_YY     = 3'd6
    } mode_e;

    localparam int unsigned SEC_MAX   = 59;
    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned HOUR_MAX  = 23;
    localparam int unsigned MONTH_MAX = 12;
    localparam int unsigned YEAR_MAX  = 99;

    // Every year divisible by four in 2000..2099 is a leap year.
    function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                      input logic [YEAR_W-1:0]  year);
        logic leap;
        leap = ((year & YEAR_W'(3)) == '0);
        case (month)
            4'd2:                      days_in_month = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   days_in_month = 5'd30;
            default:                   days_in_month = 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/rtc_field_editor_if.sv
// Mode/button/tick inputs and time/date outputs of the RTC field editor.
// blink_mask exists only when RTC_BLINK_EN is defined.
interface rtc_field_editor_if;
    import rtc_pkg::*;

    logic [MODE_W-1:0]  mode;
    logic               inc_button;
    logic               tick_1hz;
    logic [SEC_W-1:0]   sec;
    logic [MIN_W-1:0]   min;
    logic [HOUR_W-1:0]  hour;
    logic [DAY_W-1:0]   day;
    logic [MONTH_W-1:0] month;
    logic [YEAR_W-1:0]  year;
`ifdef RTC_BLINK_EN
    logic [FIELD_N-1:0] blink_mask;
`endif

    modport master (
        output mode, inc_button, tick_1hz,
        input  sec, min, hour, day, month, year
`ifdef RTC_BLINK_EN
        , input blink_mask
`endif
    );

    modport slave (
        input  mode, inc_button, tick_1hz,
        output sec, min, hour, day, month, year
`ifdef RTC_BLINK_EN
        , output blink_mask
`endif
    );

endinterface

// File: rtl/rtc_field_editor_btn_edge.sv
// Two-flop synchroniser plus rising-edge detector for a raw push button.
// Flops reset to 1 so a button held through reset release yields no pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_async,
    output logic pulse_c
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Shift the raw button through the synchroniser and history flop.
    always_comb begin
        sync1_d = btn_async;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchroniser and history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign pulse_c = sync2_q & ~prev_q;

endmodule

// File: rtl/rtc_field_editor.sv
// RTC field editor: owns the time/date registers. NORMAL (and mode 7) counts
// seconds with full carry; edit modes freeze time and bump one field without carry.
// Optional digit blinking is compiled in with RTC_BLINK_EN.
module rtc_field_editor
    import rtc_pkg::*;
`ifdef RTC_BLINK_EN
#(
    parameter int unsigned BLINK_CYCLES = 25_000_000
)
`endif
(
    input logic              clk,
    input logic              rst,
    rtc_field_editor_if.slave bus
);

    logic [SEC_W-1:0]   sec_q,   sec_d;
    logic [MIN_W-1:0]   min_q,   min_d;
    logic [HOUR_W-1:0]  hour_q,  hour_d;
    logic [DAY_W-1:0]   day_q,   day_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic [YEAR_W-1:0]  year_q,  year_d;
    logic [DAY_W-1:0]   dim_cur;
    logic [DAY_W-1:0]   dim_new;
    logic               inc_pulse;

    btn_edge u_btn_edge (
        .clk       (clk),
        .rst       (rst),
        .btn_async (bus.inc_button),
        .pulse_c   (inc_pulse)
    );

    // Next time/date: field edit in edit modes, ripple-carry tick otherwise.
    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        dim_cur = days_in_month(month_q, year_q);
        dim_new = dim_cur;
        case (bus.mode)
            MODE_SS: if (inc_pulse)
                sec_d = (sec_q >= SEC_W'(SEC_MAX)) ? '0 : sec_q + SEC_W'(1);
            MODE_MI: if (inc_pulse)
                min_d = (min_q >= MIN_W'(MIN_MAX)) ? '0 : min_q + MIN_W'(1);
            MODE_HH: if (inc_pulse)
                hour_d = (hour_q >= HOUR_W'(HOUR_MAX)) ? '0 : hour_q + HOUR_W'(1);
            MODE_DD: if (inc_pulse)
                day_d = (day_q >= dim_cur) ? DAY_W'(1) : day_q + DAY_W'(1);
            MODE_MO: if (inc_pulse) begin
                month_d = (month_q >= MONTH_W'(MONTH_MAX)) ? MONTH_W'(1) : month_q + MONTH_W'(1);
                dim_new = days_in_month(month_d, year_q);
                if (day_q > dim_new) day_d = dim_new;
            end
            MODE_YY: if (inc_pulse) begin
                year_d  = (year_q >= YEAR_W'(YEAR_MAX)) ? '0 : year_q + YEAR_W'(1);
                dim_new = days_in_month(month_q, year_d);
                if (day_q > dim_new) day_d = dim_new;
            end
            default: if (bus.tick_1hz) begin
                if (sec_q >= SEC_W'(SEC_MAX)) begin
                    sec_d = '0;
                    if (min_q >= MIN_W'(MIN_MAX)) begin
                        min_d = '0;
                        if (hour_q >= HOUR_W'(HOUR_MAX)) begin
                            hour_d = '0;
                            if (day_q >= dim_cur) begin
                                day_d = DAY_W'(1);
                                if (month_q >= MONTH_W'(MONTH_MAX)) begin
                                    month_d = MONTH_W'(1);
                                    year_d  = (year_q >= YEAR_W'(YEAR_MAX)) ? '0 : year_q + YEAR_W'(1);
                                end else begin
                                    month_d = month_q + MONTH_W'(1);
                                end
                            end else begin
                                day_d = day_q + DAY_W'(1);
                            end
                        end else begin
                            hour_d = hour_q + HOUR_W'(1);
                        end
                    end else begin
                        min_d = min_q + MIN_W'(1);
                    end
                end else begin
                    sec_d = sec_q + SEC_W'(1);
                end
            end
        endcase
    end

    // Time/date registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            day_q   <= DAY_W'(1);
            month_q <= MONTH_W'(1);
            year_q  <= '0;
        end else begin
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
        end
    end

    assign bus.sec   = sec_q;
    assign bus.min   = min_q;
    assign bus.hour  = hour_q;
    assign bus.day   = day_q;
    assign bus.month = month_q;
    assign bus.year  = year_q;

`ifdef RTC_BLINK_EN
    localparam int unsigned CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               phase_q, phase_d;
    logic [MODE_W-1:0]  mode_q,  mode_d;
    logic [FIELD_N-1:0] blink_q, blink_d;

    // Blink phase: restart on mode change so the selected field is shown first.
    always_comb begin
        mode_d  = bus.mode;
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        blink_d = '0;
        if (bus.mode != mode_q) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_W'(BLINK_CYCLES - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
        case (bus.mode)
            MODE_SS: blink_d = 6'b000001;
            MODE_MI: blink_d = 6'b000010;
            MODE_HH: blink_d = 6'b000100;
            MODE_DD: blink_d = 6'b001000;
            MODE_MO: blink_d = 6'b010000;
            MODE_YY: blink_d = 6'b100000;
            default: blink_d = '0;
        endcase
        if (!phase_d) blink_d = '0;
    end

    // Blink counter, phase and mask registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            mode_q  <= MODE_NORMAL;
            blink_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            blink_q <= blink_d;
        end
    end

    assign bus.blink_mask = blink_q;
`endif

endmodule
